// File: rtl/icache_line_responder_if.sv
// Prefetch/icache request-ack bundle plus the instruction memory read port.
// master = prefetch stage and memory side, slave = icache_line_responder.
interface icache_line_responder_if #(
  parameter int unsigned XLEN = 32
);
  logic            icache_req_i;
  logic [XLEN-1:0] icache_addr_i;
  logic            icache_kill_i;
  logic            icache_flush_i;
  logic            icache_ack_o;
  logic [XLEN-1:0] icache_rdata_o;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_ack_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            ready_o;

  modport master (
    output icache_req_i, icache_addr_i, icache_kill_i, icache_flush_i,
    output mem_ack_i, mem_rdata_i,
    input  icache_ack_o, icache_rdata_o, mem_req_o, mem_addr_o, ready_o
  );

  modport slave (
    input  icache_req_i, icache_addr_i, icache_kill_i, icache_flush_i,
    input  mem_ack_i, mem_rdata_i,
    output icache_ack_o, icache_rdata_o, mem_req_o, mem_addr_o, ready_o
  );
endinterface

// File: rtl/icache_line_responder.sv
// Direct-mapped instruction line store answering prefetch requests.
// Hits ack one cycle after sampling; misses fill a whole line from word 0
// over the memory bus, then ack the requested word.
module icache_line_responder #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_LINES  = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  icache_line_responder_if.slave bus
);
  localparam int unsigned WB   = $clog2(LINE_WORDS);
  localparam int unsigned IDX  = $clog2(NUM_LINES);
  localparam int unsigned OFF  = WB + 2;
  localparam int unsigned TAGW = XLEN - OFF - IDX;
  localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);
  localparam logic [WB-1:0]   LAST = WB'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [NUM_LINES];
  logic [XLEN-1:0]  data_q [NUM_LINES*LINE_WORDS];

  logic [TAGW-1:0]  fill_tag;
  logic [IDX-1:0]   fill_idx;
  logic [WB-1:0]    fill_word;
  logic [WB-1:0]    cnt;
  logic             kill_seen;
  logic             flush_pend;
  logic             ack_q;
  logic [XLEN-1:0]  rdata_q;
  logic             mem_req_q;
  logic [XLEN-1:0]  mem_addr_q;

  logic [TAGW-1:0]  req_tag;
  logic [IDX-1:0]   req_idx;
  logic [WB-1:0]    req_word;
  logic [WB-1:0]    cnt_nxt;
  logic             sample;
  logic             hit;
  logic             fill_last;

  // Address decode and hit detection for the request presented this cycle.
  always_comb begin
    req_word  = bus.icache_addr_i[OFF-1:2];
    req_idx   = bus.icache_addr_i[OFF+IDX-1:OFF];
    req_tag   = bus.icache_addr_i[XLEN-1:OFF+IDX];
    cnt_nxt   = cnt + 1'b1;
    sample    = (state == S_IDLE) && bus.icache_req_i && !bus.icache_kill_i;
    // A flush in the same cycle forces the sampled request down the miss path.
    hit       = sample && !bus.icache_flush_i && valid_q[req_idx] &&
                (tag_q[req_idx] == req_tag);
    fill_last = (state == S_FILL) && bus.mem_ack_i && (cnt == LAST);
  end

  // Line data and tags: written only by fill beats, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state == S_FILL && bus.mem_ack_i)
      data_q[{fill_idx, cnt}] <= bus.mem_rdata_i;
    if (fill_last)
      tag_q[fill_idx] <= fill_tag;
  end

  // Control FSM with registered ack/rdata and memory request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      valid_q    <= '0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      fill_word  <= '0;
      cnt        <= '0;
      kill_seen  <= 1'b0;
      flush_pend <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= NOP;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      rdata_q <= NOP;
      unique case (state)
        S_IDLE: begin
          if (bus.icache_flush_i)
            valid_q <= '0;
          if (sample) begin
            if (hit) begin
              ack_q   <= 1'b1;
              rdata_q <= data_q[{req_idx, req_word}];
            end else begin
              fill_tag   <= req_tag;
              fill_idx   <= req_idx;
              fill_word  <= req_word;
              cnt        <= '0;
              kill_seen  <= 1'b0;
              flush_pend <= 1'b0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {req_tag, req_idx, {WB{1'b0}}, 2'b00};
              state      <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (bus.icache_flush_i)
            flush_pend <= 1'b1;
          if (bus.icache_kill_i)
            kill_seen <= 1'b1;
          if (bus.mem_ack_i) begin
            cnt        <= cnt_nxt;
            mem_addr_q <= {fill_tag, fill_idx, cnt_nxt, 2'b00};
            if (cnt == LAST) begin
              mem_req_q         <= 1'b0;
              valid_q[fill_idx] <= 1'b1;
              if (kill_seen || bus.icache_kill_i) begin
                // Going straight to IDLE: a pending flush must still land
                // here, after (and overriding) the fresh valid bit.
                if (flush_pend || bus.icache_flush_i)
                  valid_q <= '0;
                flush_pend <= 1'b0;
                state      <= S_IDLE;
              end else begin
                state <= S_RESP;
              end
            end
          end
        end
        S_RESP: begin
          if (!bus.icache_kill_i) begin
            ack_q   <= 1'b1;
            rdata_q <= data_q[{fill_idx, fill_word}];
          end
          if (flush_pend || bus.icache_flush_i)
            valid_q <= '0;
          flush_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.icache_ack_o   = ack_q;
  assign bus.icache_rdata_o = rdata_q;
  assign bus.mem_req_o      = mem_req_q;
  assign bus.mem_addr_o     = mem_addr_q;
  assign bus.ready_o        = (state == S_IDLE);
endmodule

// File: tb/tb_icache_line_responder.sv
// Directed bench for icache_line_responder: reset, cold/conflict misses,
// kill and flush during fills, streaming hits, reset mid-fill.
module tb_icache_line_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  icache_line_responder_if #(.XLEN(32)) bus ();

  icache_line_responder #(
    .XLEN(32),
    .NUM_LINES(8),
    .LINE_WORDS(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acks  = 0;
  int ack_cyc = -1;
  int s_cyc = 0;
  int nop_bad = 0;
  logic [31:0] ack_data;
  logic [31:0] rd_q[$];

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        kill;
    logic        exp_ack;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (32'(a[15:4]) << 8) + 32'(a[3:2]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Ack monitor, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (bus.icache_ack_o === 1'b1) begin
      if (acks == 0) ack_cyc = cyc;
      acks++;
      ack_data = bus.icache_rdata_o;
    end else if (bus.icache_rdata_o !== NOP) begin
      nop_bad++;
    end
  end

  // Memory model: acks every other cycle while a request is pending.
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack_i) begin
        bus.mem_ack_i = 1'b0;
      end else if (bus.mem_req_o === 1'b1 && rst_n) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = mem_word(bus.mem_addr_o);
        rd_q.push_back(bus.mem_addr_o);
      end
    end
  end

  // One request, then a fixed window with optional kill/flush/reset pulses.
  task automatic run_req(input logic [31:0] a, input int kill_c, input int flush_c,
                         input bit flush_now, input int rst_c);
    acks = 0;
    ack_cyc = -1;
    rd_q.delete();
    @(negedge clk);
    bus.icache_req_i   = 1'b1;
    bus.icache_addr_i  = a;
    bus.icache_flush_i = flush_now;
    @(posedge clk);
    #1 s_cyc = cyc;
    @(negedge clk);
    bus.icache_req_i   = 1'b0;
    bus.icache_flush_i = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      bus.icache_kill_i  = (c == kill_c);
      bus.icache_flush_i = (c == flush_c);
      if (c == rst_c) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_fill_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_mid_fill_ack", 32'(bus.icache_ack_o), 32'd0);
      end
      if (rst_c >= 0 && c == rst_c + 3) rst_n = 1'b1;
    end
    bus.icache_kill_i  = 1'b0;
    bus.icache_flush_i = 1'b0;
  endtask

  task automatic chk_miss(input string name, input logic [31:0] a, input int exp_acks);
    logic [31:0] base;
    logic [31:0] got;
    base = {a[31:4], 4'h0};
    chk({name, "_nreads"}, 32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (i < rd_q.size()) ? rd_q[i] : 32'hDEAD_BEEF;
      chk({name, "_rdaddr"}, got, base + 32'(4 * i));
    end
    chk({name, "_acks"}, 32'(acks), 32'(exp_acks));
    if (exp_acks == 1) chk({name, "_data"}, ack_data, mem_word(a));
  endtask

  task automatic chk_hit(input string name, input logic [31:0] a);
    chk({name, "_nreads"}, 32'(rd_q.size()), 32'd0);
    chk({name, "_acks"}, 32'(acks), 32'd1);
    chk({name, "_data"}, ack_data, mem_word(a));
    chk({name, "_latency"}, 32'(ack_cyc), 32'(s_cyc));
  endtask

  initial begin
    bus.icache_req_i   = 1'b0;
    bus.icache_addr_i  = '0;
    bus.icache_kill_i  = 1'b0;
    bus.icache_flush_i = 1'b0;

    tbl[0] = '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_1000};
    tbl[1] = '{1'b1, 32'h8000_0004, 1'b0, 1'b1, 32'h0000_1001};
    tbl[2] = '{1'b1, 32'h8000_000B, 1'b0, 1'b1, 32'h0000_1002};
    tbl[3] = '{1'b1, 32'h8000_000C, 1'b0, 1'b1, 32'h0000_1003};
    tbl[4] = '{1'b0, 32'h8000_0000, 1'b0, 1'b0, NOP};
    tbl[5] = '{1'b1, 32'h8000_0004, 1'b1, 1'b0, NOP};
    tbl[6] = '{1'b1, 32'h8000_0008, 1'b0, 1'b1, 32'h0000_1002};
    tbl[7] = '{1'b1, 32'h8000_000C, 1'b1, 1'b0, NOP};

    // Reset
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ack", 32'(bus.icache_ack_o), 32'd0);
    chk("reset_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("reset_rdata", bus.icache_rdata_o, NOP);
    chk("reset_ready", 32'(bus.ready_o), 32'd1);
    chk("reset_mem_addr", bus.mem_addr_o, 32'd0);

    // Cold miss, then hit in the same line
    run_req(32'h8000_0008, -1, -1, 1'b0, -1);
    chk_miss("cold", 32'h8000_0008, 1);
    run_req(32'h8000_000C, -1, -1, 1'b0, -1);
    chk_hit("warm", 32'h8000_000C);

    // Conflict on index 0
    run_req(32'h8000_0080, -1, -1, 1'b0, -1);
    chk_miss("conflict", 32'h8000_0080, 1);
    run_req(32'h8000_0000, -1, -1, 1'b0, -1);
    chk_miss("conflict_back", 32'h8000_0000, 1);

    // Kill while word 1 is pending: full fill, no ack, line usable afterwards
    run_req(32'h8000_0014, 0, -1, 1'b0, -1);
    chk_miss("kill_fill", 32'h8000_0014, 0);
    run_req(32'h8000_0018, -1, -1, 1'b0, -1);
    chk_hit("after_kill", 32'h8000_0018);

    // Kill in RESP suppresses the ack; the line still validates
    run_req(32'h8000_0034, 6, -1, 1'b0, -1);
    chk_miss("kill_resp", 32'h8000_0034, 0);
    run_req(32'h8000_0030, -1, -1, 1'b0, -1);
    chk_hit("after_kill_resp", 32'h8000_0030);

    // Flush during fill: ack given, line invalid afterwards
    run_req(32'h8000_0024, -1, 2, 1'b0, -1);
    chk_miss("flush_fill", 32'h8000_0024, 1);
    run_req(32'h8000_0024, -1, -1, 1'b0, -1);
    chk_miss("after_flush", 32'h8000_0024, 1);

    // Flush together with a request that would hit -> miss
    run_req(32'h8000_0024, -1, -1, 1'b1, -1);
    chk_miss("flush_with_req", 32'h8000_0024, 1);

    // Re-warm line 0, then streaming table
    run_req(32'h8000_0000, -1, -1, 1'b0, -1);
    chk_miss("rewarm", 32'h8000_0000, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.icache_req_i  = tbl[i].req;
      bus.icache_addr_i = tbl[i].addr;
      bus.icache_kill_i = tbl[i].kill;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ack", i), 32'(bus.icache_ack_o), 32'(tbl[i].exp_ack));
      chk($sformatf("tbl%0d_rdata", i), bus.icache_rdata_o, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_mem_req", i), 32'(bus.mem_req_o), 32'd0);
      chk($sformatf("tbl%0d_ready", i), 32'(bus.ready_o), 32'd1);
    end
    @(negedge clk);
    bus.icache_req_i  = 1'b0;
    bus.icache_kill_i = 1'b0;

    // Reset during a fill: request drops at once, all lines invalid
    run_req(32'h8000_0040, -1, -1, 1'b0, 1);
    chk("rst_fill_acks", 32'(acks), 32'd0);
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    run_req(32'h8000_0000, -1, -1, 1'b0, -1);
    chk_miss("after_reset", 32'h8000_0000, 1);

    chk("nop_when_no_ack", 32'(nop_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
